// File: rtl/ask_tx_ctrl.sv
// ASK transmit controller: serialises bytes MSB first onto data_bit with a trailing idle gap per burst.
// Optional leading preamble byte per burst is enabled by defining ASK_PREAMBLE_EN.
module ask_tx_ctrl #(
    parameter int unsigned BIT_CYCLES = 16,
    parameter int unsigned GAP_BITS   = 2
`ifdef ASK_PREAMBLE_EN
    ,
    parameter logic [7:0]  PREAMBLE   = 8'hAA
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_bit,
    output logic       mod_en,
    output logic       bit_strobe,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DATA     = 2'd1,
        S_GAP      = 2'd2
`ifdef ASK_PREAMBLE_EN
        ,
        S_PREAMBLE = 2'd3
`endif
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(BIT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  shreg_q, shreg_d;

    logic tx_ready_q, tx_ready_d;
    logic data_bit_q, data_bit_d;
    logic mod_en_q, mod_en_d;
    logic bit_strobe_q, bit_strobe_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic hs, strobe, byte_end;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        gap_cnt_d  = gap_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shreg_d    = shreg_q;

        hs       = tx_valid & tx_ready_q;
        strobe   = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
        byte_end = strobe && (bit_idx_q == 3'd7);

        if (state_q != S_IDLE) begin
            cnt_d = strobe ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d     = 16'd0;
                bit_idx_d = 3'd0;
                gap_cnt_d = 8'd0;
                if (hs) begin
                    shreg_d = tx_data;
`ifdef ASK_PREAMBLE_EN
                    state_d = S_PREAMBLE;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef ASK_PREAMBLE_EN
            S_PREAMBLE: begin
                // The first byte already sits in the shift register; later arrivals go to the buffer.
                if (hs) begin
                    buf_d      = tx_data;
                    buf_full_d = 1'b1;
                end
                if (strobe) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (byte_end) state_d = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (strobe) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    if (byte_end) begin
                        if (buf_full_q) begin
                            shreg_d    = buf_q;
                            buf_d      = 8'd0;
                            buf_full_d = 1'b0;
                        end else if (hs) begin
                            shreg_d = tx_data;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = 8'd0;
                        end
                    end
                end
                if (hs && !byte_end) begin
                    buf_d      = tx_data;
                    buf_full_d = 1'b1;
                end
            end
            S_GAP: begin
                if (strobe) begin
                    if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                    else                       gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        case (state_d)
            S_DATA:     data_bit_d = shreg_d[7];
`ifdef ASK_PREAMBLE_EN
            S_PREAMBLE: data_bit_d = PREAMBLE[~bit_idx_d];
`endif
            default:    data_bit_d = 1'b0;
        endcase
        mod_en_d     = (state_d != S_IDLE);
        busy_d       = (state_d != S_IDLE);
        bit_strobe_d = (state_d != S_IDLE) && (cnt_d == CNT_LAST);
        frame_done_d = (state_d == S_GAP) && (cnt_d == CNT_LAST) && (gap_cnt_d == GAP_LAST);
        case (state_d)
            S_IDLE:  tx_ready_d = 1'b1;
            S_GAP:   tx_ready_d = 1'b0;
            default: tx_ready_d = !buf_full_d;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            gap_cnt_q    <= 8'd0;
            buf_q        <= 8'd0;
            buf_full_q   <= 1'b0;
            shreg_q      <= 8'd0;
            tx_ready_q   <= 1'b1;
            data_bit_q   <= 1'b0;
            mod_en_q     <= 1'b0;
            bit_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shreg_q      <= shreg_d;
            tx_ready_q   <= tx_ready_d;
            data_bit_q   <= data_bit_d;
            mod_en_q     <= mod_en_d;
            bit_strobe_q <= bit_strobe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign data_bit   = data_bit_q;
    assign mod_en     = mod_en_q;
    assign bit_strobe = bit_strobe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ask_tx_ctrl.sv
// Scoreboard bench for ask_tx_ctrl: stimulus pushes expected {data_bit, frame_done} per bit period,
// a monitor pops one entry on every bit_strobe. Preamble expectations follow ASK_PREAMBLE_EN.
module tb_ask_tx_ctrl;

    localparam int BC = 4;
    localparam int GB = 2;
    localparam logic [7:0] PRE = 8'hAA;
`ifdef ASK_PREAMBLE_EN
    localparam int LEAD = 8;
`else
    localparam int LEAD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, data_bit, mod_en, bit_strobe, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int run_len = 0;
    logic period_val = 1'b0;
    bit mon_en = 1'b1;
    logic [1:0] exp_q[$];

    ask_tx_ctrl #(.BIT_CYCLES(BC), .GAP_BITS(GB)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .data_bit(data_bit), .mod_en(mod_en),
        .bit_strobe(bit_strobe), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_start();
`ifdef ASK_PREAMBLE_EN
        logic [7:0] p;
        p = PRE;
        for (int i = 7; i >= 0; i--) exp_q.push_back({p[i], 1'b0});
`endif
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back({b[i], 1'b0});
    endtask

    task automatic push_gap();
        for (int i = 0; i < GB; i++) exp_q.push_back({1'b0, (i == GB - 1)});
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        int cyc;
        cyc = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!tx_ready) begin
            check("send_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) tx_valid = 1'b0;
        end
    endtask

    task automatic wait_strobes(input int n);
        int seen, cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (bit_strobe) seen++;
        end
        if (seen < n) check("strobe_timeout", 32'(seen), 32'(n));
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mod_en", 32'(mod_en), 32'd0);
        check("idle_tx_ready", 32'(tx_ready), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: one scoreboard entry per bit period, plus period length and stability.
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (reset || !mod_en) begin
            run_len = 0;
        end else begin
            run_len++;
            if (run_len == 1) period_val = data_bit;
            if (bit_strobe) begin
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'd1, 32'd0);
                    end else begin
                        check("bit", 32'({data_bit, frame_done}), 32'(exp_q.pop_front()));
                        check("period_len", 32'(run_len), 32'(BC));
                        check("period_stable", 32'(data_bit), 32'(period_val));
                    end
                end
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_bit", 32'(data_bit), 32'd0);
        check("rst_mod_en", 32'(mod_en), 32'd0);
        check("rst_bit_strobe", 32'(bit_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;

        // Single byte A5
        send(8'hA5, 1'b0);
        push_start();
        push_byte(8'hA5);
        push_gap();
        @(negedge clk);
        b = (LEAD != 0) ? PRE : 8'hA5;
        check("first_bit", 32'(data_bit), 32'(b[7]));
        check("first_busy", 32'(busy), 32'd1);
        check("first_mod_en", 32'(mod_en), 32'd1);
        wait_idle();
        check("single_frame_done", 32'(fd_count), 32'd1);

        // Three bytes back to back with tx_valid held high
        push_start();
        push_byte(8'hFF);
        push_byte(8'h00);
        push_byte(8'h81);
        push_gap();
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        send(8'h81, 1'b0);
        wait_idle();
        check("burst_frame_done", 32'(fd_count), 32'd2);

        // Handshake exactly on the byte-end strobe with empty buffer -> bypass
        send(8'h3C, 1'b0);
        push_start();
        push_byte(8'h3C);
        wait_strobes(LEAD + 8);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        check("bypass_ready", 32'(tx_ready), 32'd1);
        push_byte(8'h96);
        push_gap();
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("bypass_msb", 32'(data_bit), 32'd1);
        check("bypass_busy", 32'(busy), 32'd1);
        wait_idle();
        check("bypass_frame_done", 32'(fd_count), 32'd3);

        // tx_valid during GAP is held off until IDLE
        send(8'hC3, 1'b0);
        push_start();
        push_byte(8'hC3);
        push_gap();
        wait_strobes(LEAD + 8);
        @(negedge clk);
        check("gap_mod_en", 32'(mod_en), 32'd1);
        check("gap_data_bit", 32'(data_bit), 32'd0);
        check("gap_tx_ready", 32'(tx_ready), 32'd0);
        fd0 = fd_count;
        push_start();
        push_byte(8'h5A);
        push_gap();
        send(8'h5A, 1'b0);
        check("accept_after_gap", 32'(fd_count), 32'(fd0 + 1));
        wait_idle();
        check("gap_test_frame_done", 32'(fd_count), 32'(fd0 + 2));

        // Reset mid-DATA with buffer full
        mon_en = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        repeat (LEAD * BC + 5) @(negedge clk);
        check("buf_full_ready", 32'(tx_ready), 32'd0);
        check("buf_full_busy", 32'(busy), 32'd1);
        fd0 = fd_count;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_data_bit", 32'(data_bit), 32'd0);
        check("mid_rst_mod_en", 32'(mod_en), 32'd0);
        check("mid_rst_bit_strobe", 32'(bit_strobe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("no_frame_done_after_rst", 32'(fd_count), 32'(fd0));
        check("idle_after_rst", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // Fresh burst after reset works normally
        send(8'h6E, 1'b0);
        push_start();
        push_byte(8'h6E);
        push_gap();
        wait_idle();
        check("post_rst_frame_done", 32'(fd_count), 32'(fd0 + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ask_tx_ctrl.md
ASK_TX_CTRL -- requirements
Module: ask_tx_ctrl

Interface
REQ-001 Parameter BIT_CYCLES, default 16: clk cycles per transmitted bit; legal range 2..65535.
REQ-002 Parameter GAP_BITS, default 2: idle bit periods (data_bit=0) appended after the last byte of a burst; legal range 1..255.
REQ-003 Parameter PREAMBLE, default 8'hAA: byte sent before each burst when ASK_PREAMBLE_EN is defined.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit; sampled on handshake.
REQ-007 tx_valid  input  1  tx_data valid.
REQ-008 tx_ready  output  1  holding buffer empty; handshake = tx_valid & tx_ready.
REQ-009 data_bit  output  1  serial keying bit to the ASK modulator's data input.
REQ-010 mod_en  output  1  modulator enable; high in PREAMBLE, DATA and GAP.
REQ-011 bit_strobe  output  1  one-cycle pulse on the last clk of every bit period (preamble, data and gap bits).
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 frame_done  output  1  one-cycle pulse on the cycle GAP ends.

Function
REQ-014 States: IDLE, PREAMBLE, DATA, GAP; all outputs registered.
REQ-015 Storage: one 8-bit holding buffer plus 8-bit shift register; tx_ready = holding buffer empty.
REQ-016 IDLE: handshake in cycle N -> byte loaded into shift register (buffer stays empty), state at N+1 = PREAMBLE (macro defined) or DATA; first bit on data_bit from N+1.
REQ-017 Bit timing: 16-bit cycle counter counts 0..BIT_CYCLES-1 per bit; data_bit constant for exactly BIT_CYCLES cycles; bit_strobe high when counter = BIT_CYCLES-1.
REQ-018 Bit order MSB first; 3-bit bit index wraps 7 -> 0 at each byte end.
REQ-019 PREAMBLE: shifts out PREAMBLE MSB first, then DATA with no gap cycle.
REQ-020 DATA, byte end (bit 7 strobe): if buffer full -> buffer moves to shift register, buffer cleared, stay DATA.
REQ-021 DATA, byte end with buffer empty and handshake in the same cycle -> tx_data bypasses straight into shift register, stay DATA (back-to-back, no lost cycles).
REQ-022 DATA, byte end, buffer empty, no handshake -> GAP with data_bit=0.
REQ-023 Handshake during DATA not at byte end -> byte written to buffer; tx_ready low next cycle.
REQ-024 GAP: data_bit=0, mod_en=1 for GAP_BITS bit periods; tx_ready stays low in GAP (no accepts); at last gap strobe -> frame_done=1 that cycle, IDLE next cycle.
REQ-025 IDLE: data_bit=0, mod_en=0, busy=0, tx_ready=1, counters held at 0.
REQ-026 tx_valid without tx_ready: no state change; data held by upstream.

Reset
REQ-027 reset high at a rising edge: state IDLE, counters 0, buffer and shift register cleared next cycle, regardless of current state.
REQ-028 Reset values: data_bit=0, mod_en=0, bit_strobe=0, busy=0, frame_done=0, tx_ready=1; no handshake accepted while reset high.
REQ-029 Reset mid-byte discards in-flight and buffered bytes; no frame_done issued.

Configuration
REQ-030 Macro ASK_PREAMBLE_EN defined: PREAMBLE state present, each burst starts with 8 PREAMBLE bits.
REQ-031 Macro undefined: PREAMBLE state and logic absent; IDLE goes directly to DATA; all other behaviour identical.

Verification
REQ-032 BIT_CYCLES=4, macro off, one byte 8'hA5 -> data_bit 1,0,1,0,0,1,0,1 each 4 cycles from cycle after handshake, 8 strobes, then 8 cycles of 0, frame_done, IDLE.
REQ-033 Macro on, byte 8'h0F -> 32 cycles of 1,0,1,0,1,0,1,0 then 0,0,0,0,1,1,1,1; busy high throughout.
REQ-034 tx_valid held high with 3 bytes 8'hFF,8'h00,8'h81 -> 24 contiguous bit periods, no gap between bytes, single frame_done after gap.
REQ-035 Buffer empty, handshake exactly on bit-7 strobe -> bypass load, next byte's MSB in next cycle, no GAP entry.
REQ-036 reset asserted mid-DATA with buffer full -> next cycle all outputs at reset values, tx_ready=1, no frame_done.
REQ-037 tx_valid asserted during GAP -> tx_ready=0, byte not accepted until IDLE, then new burst starts normally.
